// File: rtl/shiftreg_feeder.sv
// Byte FIFO feeding a shift-register driver through an EN/RDY handshake.
// Sticky flags report writes rejected while full and bytes dropped when the driver never answers.
module shiftreg_feeder #(
  parameter int DEPTH_LOG2     = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                WR_EN,
  input  logic [7:0]          WR_DATA,
  input  logic                CLR_ERR,
  input  logic                RDY,
  output logic [7:0]          BYTE_OUT,
  output logic                EN_OUT,
  output logic                FULL,
  output logic                EMPTY,
  output logic [DEPTH_LOG2:0] COUNT,
  output logic                OVERFLOW,
  output logic                TIMEOUT_ERR
);

  // state | meaning
  // IDLE  | strobe low; start a transfer when a byte is queued and the driver is ready
  // REQ   | strobe high with the head byte; wait for the driver to drop RDY or time out
  // BUSY  | driver is shifting; wait for RDY to return
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_BUSY} state_t;

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [15:0]         TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t                  state_q, state_d;
  logic [7:0]              mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic                    full_q, full_d;
  logic                    empty_q, empty_d;
  logic                    en_out_q, en_out_d;
  logic [7:0]              byte_out_q, byte_out_d;
  logic                    ovf_q, ovf_d;
  logic                    tmo_err_q, tmo_err_d;
  logic [15:0]             tmo_cnt_q, tmo_cnt_d;
  logic                    push, pop, ovf_set, tmo_set;

  // A write while full is rejected even when a pop frees a slot in the same cycle.
  assign push    = WR_EN & ~full_q;
  assign ovf_set = WR_EN & full_q;

  always_comb begin
    state_d    = state_q;
    en_out_d   = en_out_q;
    byte_out_d = byte_out_q;
    tmo_cnt_d  = tmo_cnt_q;
    pop        = 1'b0;
    tmo_set    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        en_out_d = 1'b0;
        if (!empty_q && RDY) begin
          byte_out_d = mem[rd_ptr_q];
          en_out_d   = 1'b1;
          tmo_cnt_d  = '0;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!RDY) begin
          en_out_d = 1'b0;
          pop      = 1'b1;
          state_d  = ST_BUSY;
        end else if (tmo_cnt_q + 16'd1 >= TMO_LIMIT) begin
          en_out_d = 1'b0;
          pop      = 1'b1;
          tmo_set  = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
      ST_BUSY: begin
        en_out_d = 1'b0;
        if (RDY) state_d = ST_IDLE;
      end
      default: begin
        en_out_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
      default: count_d = count_q;
    endcase
    full_d    = (count_d == DEPTH_CNT);
    empty_d   = (count_d == '0);
    ovf_d     = ovf_set | (ovf_q & ~CLR_ERR);
    tmo_err_d = tmo_set | (tmo_err_q & ~CLR_ERR);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      en_out_q   <= 1'b0;
      byte_out_q <= 8'h00;
      ovf_q      <= 1'b0;
      tmo_err_q  <= 1'b0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      en_out_q   <= en_out_d;
      byte_out_q <= byte_out_d;
      ovf_q      <= ovf_d;
      tmo_err_q  <= tmo_err_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  // Storage needs no reset: EMPTY guards every read until a slot is rewritten.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_q] <= WR_DATA;
  end

  assign BYTE_OUT    = byte_out_q;
  assign EN_OUT      = en_out_q;
  assign FULL        = full_q;
  assign EMPTY       = empty_q;
  assign COUNT       = count_q;
  assign OVERFLOW    = ovf_q;
  assign TIMEOUT_ERR = tmo_err_q;

endmodule

// File: tb/tb_shiftreg_feeder.sv
// Directed bench for shiftreg_feeder: single byte, burst/overflow, timeout, wrap, async reset.
module tb_shiftreg_feeder;
  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       WR_EN = 1'b0;
  logic [7:0] WR_DATA = 8'h00;
  logic       CLR_ERR = 1'b0;
  logic       RDY = 1'b1;
  logic [7:0] BYTE_OUT;
  logic       EN_OUT;
  logic       FULL;
  logic       EMPTY;
  logic [3:0] COUNT;
  logic       OVERFLOW;
  logic       TIMEOUT_ERR;

  int n_vec = 0;
  int n_miscmp = 0;

  shiftreg_feeder #(.DEPTH_LOG2(3), .TIMEOUT_CYCLES(255)) dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .CLR_ERR(CLR_ERR),
    .RDY(RDY), .BYTE_OUT(BYTE_OUT), .EN_OUT(EN_OUT), .FULL(FULL), .EMPTY(EMPTY),
    .COUNT(COUNT), .OVERFLOW(OVERFLOW), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Driver model: raise RDY, wait for the strobe, check the byte, acknowledge with RDY low.
  task automatic drive_byte(input string tag, input logic [7:0] exp);
    int n = 0;
    RDY = 1'b1;
    while (!EN_OUT && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_en"}, EN_OUT, 1);
    chk({tag, "_byte"}, BYTE_OUT, exp);
    RDY = 1'b0;
    tick();
    chk({tag, "_en_drop"}, EN_OUT, 0);
    RDY = 1'b1;
  endtask

  initial begin
    #1 RST = 1'b1;
    #2;
    chk("rst_en", EN_OUT, 0);
    chk("rst_count", COUNT, 0);
    chk("rst_empty", EMPTY, 1);
    chk("rst_full", FULL, 0);
    chk("rst_byte", BYTE_OUT, 8'h00);
    chk("rst_ovf", OVERFLOW, 0);
    chk("rst_tmo", TIMEOUT_ERR, 0);
    @(negedge CLK);
    tick();
    RST = 1'b0;
    tick();

    // single byte, idle with RDY high
    WR_EN = 1'b1; WR_DATA = 8'hA5;
    tick();
    WR_EN = 1'b0;
    chk("sb_en_k", EN_OUT, 0);
    chk("sb_count", COUNT, 1);
    tick();
    chk("sb_en_k1", EN_OUT, 1);
    chk("sb_byte", BYTE_OUT, 8'hA5);
    RDY = 1'b0;
    tick();
    chk("sb_en_fall", EN_OUT, 0);
    chk("sb_empty", EMPTY, 1);
    RDY = 1'b1;
    tick();
    tick();
    chk("sb_idle_en", EN_OUT, 0);

    // burst of eight with the driver holding RDY low, then overflow
    RDY = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      WR_EN = 1'b1; WR_DATA = 8'(i);
      tick();
    end
    chk("burst_full", FULL, 1);
    chk("burst_count", COUNT, 8);
    chk("burst_ovf0", OVERFLOW, 0);
    WR_DATA = 8'h09;
    tick();
    chk("ovf_set", OVERFLOW, 1);
    chk("ovf_count", COUNT, 8);
    WR_DATA = 8'h0A; CLR_ERR = 1'b1;
    tick();
    chk("ovf_set_beats_clr", OVERFLOW, 1);
    WR_EN = 1'b0;
    tick();
    chk("ovf_clr", OVERFLOW, 0);
    CLR_ERR = 1'b0;
    RDY = 1'b1;
    tick();
    chk("burst_b1_en", EN_OUT, 1);
    chk("burst_b1_byte", BYTE_OUT, 8'h01);
    RDY = 1'b0; WR_EN = 1'b1; WR_DATA = 8'hEE;
    tick();
    WR_EN = 1'b0;
    chk("ovf_pop_count", COUNT, 7);
    chk("ovf_pop_flag", OVERFLOW, 1);
    chk("ovf_pop_en", EN_OUT, 0);
    for (int i = 2; i <= 8; i++) drive_byte($sformatf("burst_b%0d", i), 8'(i));
    repeat (4) tick();
    chk("burst_no_extra", EN_OUT, 0);
    chk("burst_empty", EMPTY, 1);
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;

    // timeout: driver never answers
    WR_EN = 1'b1; WR_DATA = 8'h3C;
    tick();
    WR_EN = 1'b0;
    tick();
    chk("tmo_start_en", EN_OUT, 1);
    chk("tmo_start_byte", BYTE_OUT, 8'h3C);
    repeat (254) tick();
    chk("tmo_pre_en", EN_OUT, 1);
    chk("tmo_pre_err", TIMEOUT_ERR, 0);
    chk("tmo_pre_count", COUNT, 1);
    tick();
    chk("tmo_en", EN_OUT, 0);
    chk("tmo_err", TIMEOUT_ERR, 1);
    chk("tmo_count", COUNT, 0);
    repeat (3) tick();
    chk("tmo_no_retry", EN_OUT, 0);
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    chk("tmo_clr", TIMEOUT_ERR, 0);

    // fill to seven across the pointer wrap, then push and pop together
    RDY = 1'b0;
    for (int i = 0; i < 7; i++) begin
      WR_EN = 1'b1; WR_DATA = 8'h10 + 8'(i);
      tick();
    end
    WR_EN = 1'b0;
    chk("wrap_count7", COUNT, 7);
    chk("wrap_notfull", FULL, 0);
    RDY = 1'b1;
    tick();
    chk("wrap_b0_en", EN_OUT, 1);
    chk("wrap_b0_byte", BYTE_OUT, 8'h10);
    RDY = 1'b0; WR_EN = 1'b1; WR_DATA = 8'h17;
    tick();
    WR_EN = 1'b0;
    chk("wrap_simul_count", COUNT, 7);
    chk("wrap_simul_en", EN_OUT, 0);
    for (int i = 1; i <= 7; i++) drive_byte($sformatf("wrap_b%0d", i), 8'h10 + 8'(i));
    tick();
    chk("wrap_empty", EMPTY, 1);

    // asynchronous reset while strobing with three bytes queued
    RDY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      WR_EN = 1'b1; WR_DATA = 8'h21 + 8'(i);
      tick();
    end
    WR_EN = 1'b0;
    RDY = 1'b1;
    tick();
    chk("mrst_pre_en", EN_OUT, 1);
    chk("mrst_pre_count", COUNT, 3);
    RST = 1'b1;
    #1;
    chk("mrst_en", EN_OUT, 0);
    chk("mrst_count", COUNT, 0);
    chk("mrst_empty", EMPTY, 1);
    chk("mrst_byte", BYTE_OUT, 8'h00);
    @(negedge CLK);
    tick();
    RST = 1'b0;
    repeat (3) tick();
    chk("mrst_no_stale", EN_OUT, 0);
    chk("mrst_still_empty", EMPTY, 1);
    WR_EN = 1'b1; WR_DATA = 8'h5A;
    tick();
    WR_EN = 1'b0;
    drive_byte("post_rst", 8'h5A);
    tick();
    chk("post_rst_empty", EMPTY, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed simulation still running, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/shiftreg_feeder.md
SHIFTREG_FEEDER -- requirements
Module: shiftreg_feeder

Interface
REQ-001 The block SHALL use parameter DEPTH_LOG2, default 3, as log2 of the FIFO depth (8 entries).
REQ-002 The block SHALL use parameter TIMEOUT_CYCLES, default 255, as the maximum number of REQ-state cycles spent waiting for RDY low (16-bit counter).
REQ-003 The block SHALL have port CLK  input  1  system clock, rising edge.
REQ-004 The block SHALL have port RST  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 The block SHALL have port WR_EN  input  1  push request for WR_DATA.
REQ-006 The block SHALL have port WR_DATA  input  8  byte to enqueue.
REQ-007 The block SHALL have port CLR_ERR  input  1  synchronous clear of the sticky error flags.
REQ-008 The block SHALL have port RDY  input  1  ready flag from the downstream shift-register driver.
REQ-009 The block SHALL have port BYTE_OUT  output  8  byte presented to the driver's BYTE_IN.
REQ-010 The block SHALL have port EN_OUT  output  1  data-valid strobe to the driver's EN_IN.
REQ-011 The block SHALL have port FULL  output  1  FIFO holds 2^DEPTH_LOG2 entries.
REQ-012 The block SHALL have port EMPTY  output  1  FIFO holds 0 entries.
REQ-013 The block SHALL have port COUNT  output  DEPTH_LOG2+1  FIFO occupancy.
REQ-014 The block SHALL have port OVERFLOW  output  1  sticky flag for a write rejected while full.
REQ-015 The block SHALL have port TIMEOUT_ERR  output  1  sticky flag for a byte dropped on handshake timeout.

Function
REQ-016 The FIFO SHALL be a circular buffer with read/write pointers of DEPTH_LOG2 bits that wrap modulo depth; COUNT, FULL and EMPTY SHALL be registered and consistent in every cycle.
REQ-017 A WR_EN while FULL=0 SHALL store WR_DATA at the write edge; a WR_EN while FULL=1 SHALL be discarded and set OVERFLOW, even if a pop occurs in the same cycle.
REQ-018 A simultaneous accepted push and pop SHALL leave COUNT unchanged.
REQ-019 The FSM SHALL have exactly three states: IDLE, REQ, BUSY.
REQ-020 IDLE: if EMPTY=0 and RDY=1, the FSM SHALL load BYTE_OUT with the FIFO head, set EN_OUT=1, clear the timeout counter, and go to REQ; otherwise EN_OUT SHALL be 0.
REQ-021 REQ: EN_OUT and BYTE_OUT SHALL be held stable; on RDY=0 the FSM SHALL clear EN_OUT, pop the FIFO, and go to BUSY.
REQ-022 REQ: if the counter reaches TIMEOUT_CYCLES with RDY still 1, the FSM SHALL clear EN_OUT, pop (drop) the byte, set TIMEOUT_ERR, and go to IDLE.
REQ-023 BUSY: EN_OUT SHALL be 0; on RDY=1 the FSM SHALL go to IDLE.
REQ-024 EN_OUT SHALL never be 1 in the cycle after RDY is sampled 0 in REQ, so the driver never restarts on a stale strobe.
REQ-025 A byte written to an empty FIFO in IDLE with RDY=1 at edge k SHALL produce EN_OUT=1 after edge k+1.
REQ-026 Bytes SHALL be delivered in write order with no duplication; back-to-back transfers SHALL need no gap beyond one IDLE cycle.
REQ-027 CLR_ERR SHALL clear OVERFLOW and TIMEOUT_ERR at the next edge; a same-cycle set event SHALL take priority over the clear.

Reset
REQ-028 While RST=1, the block SHALL immediately force: FSM=IDLE, pointers=0, COUNT=0, EMPTY=1, FULL=0, EN_OUT=0, BYTE_OUT=8'h00, OVERFLOW=0, TIMEOUT_ERR=0, timeout counter=0.
REQ-029 Reset asserted mid-transfer SHALL drop EN_OUT asynchronously and discard all queued bytes; FIFO contents SHALL not be read after reset until rewritten.

Verification
REQ-030 Single byte: write 8'hA5 while idle with RDY=1 -> EN_OUT=1 after 2 edges, BYTE_OUT=8'hA5, EN_OUT falls on the edge after RDY=0, EMPTY=1.
REQ-031 Burst: write 8'h01..8'h08 in consecutive cycles against a driver model -> FULL=1 after the 8th write and bytes delivered in order 01..08; a 9th write while full -> OVERFLOW=1 and the byte is never delivered.
REQ-032 Timeout: queue 8'h3C with RDY held 1 and no response -> after TIMEOUT_CYCLES in REQ, EN_OUT=0, TIMEOUT_ERR=1, COUNT decremented; CLR_ERR -> TIMEOUT_ERR=0.
REQ-033 Wrap/simultaneity: fill to 7, then push and pop in the same cycle across pointer wrap -> COUNT stays 7, order preserved.
REQ-034 Reset mid-REQ: assert RST with EN_OUT=1 and COUNT=3 -> EN_OUT=0, COUNT=0, EMPTY=1 without waiting for a clock edge.
